// File: rtl/i2s_audio_transmitter_if.sv
// Sample producer handshake for the I2S transmitter: one stereo pair per valid/ready transfer.
interface i2s_audio_transmitter_if #(
  parameter int unsigned sample_width = 16
);
  logic [sample_width-1:0] left;
  logic [sample_width-1:0] right;
  logic                    sample_valid;
  logic                    sample_ready;

  modport master (output left, right, sample_valid, input sample_ready);
  modport slave  (input left, right, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_audio_transmitter.sv
// Philips I2S bus-master transmitter: generates sck/ws from clk and shifts stereo PCM out MSB-first
// in 32-bit slots, fed through a one-entry holding buffer.
module i2s_audio_transmitter #(
  parameter int unsigned sample_width    = 16,
  parameter int unsigned sck_half_period = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  i2s_audio_transmitter_if.slave smp,
  output logic                   underflow,
  output logic                   busy,
  output logic                   sck,
  output logic                   ws,
  output logic                   sd
);
  localparam int unsigned div_w = (sck_half_period > 1) ? $clog2(sck_half_period) : 1;
  localparam logic [div_w-1:0] div_last = div_w'(sck_half_period - 1);
  localparam int unsigned pad_w = 32 - sample_width;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [div_w-1:0]        div_cnt, div_nxt;
  logic [5:0]              bit_cnt, bit_nxt, bit_new;
  logic                    sck_nxt, ws_nxt, sd_nxt, underflow_nxt, busy_nxt;
  logic                    buf_empty, buf_empty_nxt;
  logic [sample_width-1:0] buf_left, buf_right, buf_left_nxt, buf_right_nxt;
  logic [sample_width-1:0] tx_left, tx_right, tx_left_nxt, tx_right_nxt, tx_sel;
  logic [31:0]             slot;
  logic                    run, fall;

  assign smp.sample_ready = buf_empty;

  // Next-state, divider, frame load and serializer
  always_comb begin
    state_nxt     = state;
    div_nxt       = div_cnt;
    bit_nxt       = bit_cnt;
    sck_nxt       = sck;
    ws_nxt        = ws;
    sd_nxt        = sd;
    underflow_nxt = 1'b0;
    buf_empty_nxt = buf_empty;
    buf_left_nxt  = buf_left;
    buf_right_nxt = buf_right;
    tx_left_nxt   = tx_left;
    tx_right_nxt  = tx_right;
    tx_sel        = '0;
    slot          = '0;
    bit_new       = bit_cnt + 6'd1;
    run           = (state != IDLE) || en;
    fall          = run && (div_cnt == div_last) && sck;

    if (smp.sample_valid && buf_empty) begin
      buf_left_nxt  = smp.left;
      buf_right_nxt = smp.right;
      buf_empty_nxt = 1'b0;
    end

    case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN:   if (en)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase

    if (run) begin
      if (div_cnt == div_last) begin
        div_nxt = '0;
        sck_nxt = ~sck;
      end else begin
        div_nxt = div_cnt + div_w'(1);
      end
    end

    if (fall) begin
      if ((bit_new == 6'd0) && (state == DRAIN) && !en) begin
        state_nxt = IDLE;
        bit_nxt   = 6'd63;
        ws_nxt    = 1'b0;
        sd_nxt    = 1'b0;
        div_nxt   = '0;
      end else begin
        // Frame boundary: take the buffered pair, or repeat the last one and flag it
        if (bit_new == 6'd0) begin
          if (!buf_empty) begin
            tx_left_nxt   = buf_left;
            tx_right_nxt  = buf_right;
            buf_empty_nxt = 1'b1;
          end else begin
            underflow_nxt = 1'b1;
          end
        end
        bit_nxt = bit_new;
        ws_nxt  = (bit_new >= 6'd31) && (bit_new != 6'd63);
        tx_sel  = bit_new[5] ? tx_right_nxt : tx_left_nxt;
        slot    = 32'(tx_sel) << pad_w;
        sd_nxt  = slot[~bit_new[4:0]];
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= 6'd63;
      sck       <= 1'b0;
      ws        <= 1'b0;
      sd        <= 1'b0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      buf_empty <= 1'b1;
      buf_left  <= '0;
      buf_right <= '0;
      tx_left   <= '0;
      tx_right  <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      sck       <= sck_nxt;
      ws        <= ws_nxt;
      sd        <= sd_nxt;
      underflow <= underflow_nxt;
      busy      <= busy_nxt;
      buf_empty <= buf_empty_nxt;
      buf_left  <= buf_left_nxt;
      buf_right <= buf_right_nxt;
      tx_left   <= tx_left_nxt;
      tx_right  <= tx_right_nxt;
    end
  end
endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// Scoreboard bench for i2s_audio_transmitter: expected (ws, sd) per sck rising edge are queued by
// the stimulus and popped by per-instance monitors.
module tb_i2s_audio_transmitter;
  localparam int unsigned sw_a  = 16;
  localparam int unsigned shp_a = 2;
  localparam int unsigned sw_b  = 24;
  localparam int unsigned shp_b = 1;

  typedef struct packed {logic ws; logic sd;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic ufl_a, busy_a, sck_a, ws_a, sd_a;
  logic ufl_b, busy_b, sck_b, ws_b, sd_b;

  i2s_audio_transmitter_if #(.sample_width(sw_a)) ifa ();
  i2s_audio_transmitter_if #(.sample_width(sw_b)) ifb ();

  i2s_audio_transmitter #(.sample_width(sw_a), .sck_half_period(shp_a)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .smp(ifa),
    .underflow(ufl_a), .busy(busy_a), .sck(sck_a), .ws(ws_a), .sd(sd_a));

  i2s_audio_transmitter #(.sample_width(sw_b), .sck_half_period(shp_b)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .smp(ifb),
    .underflow(ufl_b), .busy(busy_b), .sck(sck_b), .ws(ws_b), .sd(sd_b));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic mon_a = 1'b0;
  logic mon_b = 1'b0;
  logic sck_a_prev = 1'b0;
  logic sck_b_prev = 1'b0;
  int   n_ufl_a = 0;
  int   n_acc_a = 0;
  logic acc_a = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  function automatic logic slot_bit(input logic [31:0] s, input int w, input int j);
    if (j < w) return s[w-1-j];
    return 1'b0;
  endfunction

  function automatic void push_exp(input int sel, input exp_t e);
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
  endfunction

  // The rising edge before the first fall after leaving IDLE shows ws=0, sd=0
  function automatic void push_dummy(input int sel);
    exp_t e;
    e.ws = 1'b0;
    e.sd = 1'b0;
    push_exp(sel, e);
  endfunction

  function automatic void push_frame(input int sel, input logic [31:0] l, input logic [31:0] r, input int w);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.ws = (((k + 1) % 64) >= 32);
      e.sd = (k < 32) ? slot_bit(l, w, k) : slot_bit(r, w, k - 32);
      push_exp(sel, e);
    end
  endfunction

  function automatic logic [15:0] pl(input int i);
    return 16'(32'h1234 + i * 32'h0101);
  endfunction

  function automatic logic [15:0] pr(input int i);
    return ~pl(i);
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? qa.size() : qb.size();
  endfunction

  always @(posedge clk) begin
    acc_a = ifa.sample_valid && ifa.sample_ready;
    if (acc_a) n_acc_a++;
  end

  // Monitors: sample on the falling clk edge, act on each sck rising edge
  always @(negedge clk) begin
    exp_t e;
    if (rst && ufl_a) n_ufl_a++;
    if (rst && mon_a && sck_a && !sck_a_prev) begin
      if (qa.size() == 0) flag_fail("extra_bit_a");
      else begin
        e = qa.pop_front();
        check("bit_a", 32'({ws_a, sd_a}), 32'(e));
      end
    end
    sck_a_prev = sck_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && mon_b && sck_b && !sck_b_prev) begin
      if (qb.size() == 0) flag_fail("extra_bit_b");
      else begin
        e = qb.pop_front();
        check("bit_b", 32'({ws_b, sd_b}), 32'(e));
      end
    end
    sck_b_prev = sck_b;
  end

  task automatic wait_size(input int sel, input int n);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (qsize(sel) <= n) return;
    end
    flag_fail("wait_size_timeout");
  endtask

  task automatic wait_idle(input int sel);
    logic b;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      b = (sel == 0) ? busy_a : busy_b;
      if (!b) begin
        check("frame_drained", 32'(qsize(sel)), 32'd0);
        if (sel == 0) check("idle_outs_a", 32'({sck_a, ws_a, sd_a}), 32'd0);
        else          check("idle_outs_b", 32'({sck_b, ws_b, sd_b}), 32'd0);
        return;
      end
    end
    flag_fail("wait_idle_timeout");
  endtask

  task automatic measure_period(input int sel, input int expv);
    logic prev, cur, found;
    int   cnt;
    found = 1'b0;
    cnt   = 0;
    prev  = (sel == 0) ? sck_a : sck_b;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      cur = (sel == 0) ? sck_a : sck_b;
      if (cur && !prev) found = 1'b1;
      prev = cur;
    end
    if (!found) begin
      flag_fail("sck_period_timeout");
      return;
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      cnt++;
      cur = (sel == 0) ? sck_a : sck_b;
      if (cur && !prev) found = 1'b1;
      prev = cur;
    end
    check("sck_period", 32'(cnt), 32'(expv));
  endtask

  initial begin
    int   fidx;
    logic done;
    ifa.left = '0; ifa.right = '0; ifa.sample_valid = 1'b0;
    ifb.left = '0; ifb.right = '0; ifb.sample_valid = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", 32'({sck_a, ws_a, sd_a, busy_a, ufl_a}), 32'd0);
    check("reset_ready_a", 32'(ifa.sample_ready), 32'd1);
    check("reset_outs_b", 32'({sck_b, ws_b, sd_b, busy_b, ufl_b}), 32'd0);
    check("reset_ready_b", 32'(ifb.sample_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Preloaded pair, then a repeated frame with one underflow pulse
    ifa.left = 16'hA5C3; ifa.right = 16'h0F01; ifa.sample_valid = 1'b1;
    @(negedge clk);
    ifa.sample_valid = 1'b0;
    check("ready_full", 32'(ifa.sample_ready), 32'd0);
    push_dummy(0);
    push_frame(0, 32'h0000A5C3, 32'h00000F01, 16);
    push_frame(0, 32'h0000A5C3, 32'h00000F01, 16);
    n_ufl_a = 0;
    mon_a   = 1'b1;
    en_a    = 1'b1;
    measure_period(0, 4);
    wait_size(0, 56);
    en_a = 1'b0;
    wait_idle(0);
    check("repeat_underflow", 32'(n_ufl_a), 32'd1);
    check("repeat_ready", 32'(ifa.sample_ready), 32'd1);

    // Back-to-back producer: one pair per frame, nothing lost
    n_ufl_a = 0;
    n_acc_a = 0;
    push_dummy(0);
    for (int i = 0; i < 4; i++) push_frame(0, 32'(pl(i)), 32'(pr(i)), 16);
    fidx = 0;
    ifa.left = pl(0); ifa.right = pr(0); ifa.sample_valid = 1'b1;
    en_a = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (acc_a) begin
        fidx++;
        ifa.left  = pl(fidx);
        ifa.right = pr(fidx);
      end
      if (en_a && qa.size() <= 40) en_a = 1'b0;
      if (!en_a && !busy_a) done = 1'b1;
    end
    ifa.sample_valid = 1'b0;
    if (!done) flag_fail("feed_timeout");
    check("feed_drained", 32'(qa.size()), 32'd0);
    check("feed_accepts", 32'(n_acc_a), 32'd5);
    check("feed_underflow", 32'(n_ufl_a), 32'd0);
    check("feed_buffer_held", 32'(ifa.sample_ready), 32'd0);

    // en re-raised while draining keeps streaming without a gap
    n_ufl_a = 0;
    push_dummy(0);
    push_frame(0, 32'(pl(4)), 32'(pr(4)), 16);
    push_frame(0, 32'(pl(4)), 32'(pr(4)), 16);
    en_a = 1'b1;
    wait_size(0, 110);
    en_a = 1'b0;
    wait_size(0, 100);
    check("drain_busy", 32'(busy_a), 32'd1);
    en_a = 1'b1;
    wait_size(0, 40);
    en_a = 1'b0;
    wait_idle(0);
    check("resume_underflow", 32'(n_ufl_a), 32'd1);

    // Asynchronous reset mid-frame
    mon_a = 1'b0;
    qa.delete();
    en_a = 1'b1;
    repeat (40) @(negedge clk);
    ifa.left = 16'h1111; ifa.right = 16'h2222; ifa.sample_valid = 1'b1;
    @(negedge clk);
    ifa.sample_valid = 1'b0;
    check("pre_reset_ready", 32'(ifa.sample_ready), 32'd0);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outs", 32'({sck_a, ws_a, sd_a, busy_a}), 32'd0);
    check("async_reset_ready", 32'(ifa.sample_ready), 32'd1);
    @(negedge clk);
    n_ufl_a = 0;
    push_dummy(0);
    push_frame(0, 32'd0, 32'd0, 16);
    sck_a_prev = sck_a;
    mon_a = 1'b1;
    rst   = 1'b1;
    wait_size(0, 40);
    en_a = 1'b0;
    wait_idle(0);
    check("post_reset_underflow", 32'(n_ufl_a), 32'd1);

    // 24-bit samples at sck = clk/2
    ifb.left = 24'h800001; ifb.right = 24'h00F00F; ifb.sample_valid = 1'b1;
    @(negedge clk);
    ifb.sample_valid = 1'b0;
    push_dummy(1);
    push_frame(1, 32'h00800001, 32'h0000F00F, 24);
    mon_b = 1'b1;
    en_b  = 1'b1;
    measure_period(1, 2);
    wait_size(1, 40);
    en_b = 1'b0;
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
